matmul_sequencer: RTL

Run-level sequencer for the 128-lane matmul datapath, running in the PL clock domain. It latches a runtime tile shape and walks the A and B input BRAM row addresses in row-major order, one operand pair per cycle. It tracks each pair through the fixed BRAM-read plus adder-tree pipeline latency and issues the matching output-memory write (port b) with a linear result address. It reports busy/done and supports synchronous abort.

---
 rtl/matmul_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/matmul_sequencer.sv
// Run-level sequencer for the 128-lane matmul datapath: walks A/B row addresses
// row-major, tracks operand pairs through the read+adder-tree latency and emits result writes.
module matmul_sequencer #(
    parameter int A_ADDR_WIDTH   = 6,
    parameter int B_ADDR_WIDTH   = 6,
    parameter int OUT_ADDR_WIDTH = 12,
    parameter int PIPE_LAT       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [A_ADDR_WIDTH-1:0]   cfg_rows_a,
    input  logic [B_ADDR_WIDTH-1:0]   cfg_rows_b,
    output logic                      en_A,
    output logic                      en_B,
    output logic                      we_A,
    output logic                      we_B,
    output logic [A_ADDR_WIDTH-1:0]   addr_A,
    output logic [B_ADDR_WIDTH-1:0]   addr_B,
    output logic                      en_out,
    output logic                      we_out,
    output logic [OUT_ADDR_WIDTH-1:0] addr_out,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Only the tail bit set means the final result is being written this cycle.
    localparam logic [PIPE_LAT-1:0] TAIL_ONLY = PIPE_LAT'(1) << (PIPE_LAT - 1);

    state_t                    state_q, state_d;
    logic [A_ADDR_WIDTH-1:0]   cfg_a_q, cfg_a_d;
    logic [B_ADDR_WIDTH-1:0]   cfg_b_q, cfg_b_d;
    logic [A_ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
    logic [B_ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
    logic                      en_ab_q, en_ab_d;
    logic [PIPE_LAT-1:0]       vld_pipe_q, vld_pipe_d;
    logic [OUT_ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cfg_a_d    = cfg_a_q;
        cfg_b_d    = cfg_b_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        en_ab_d    = en_ab_q;
        vld_pipe_d = (vld_pipe_q << 1) | PIPE_LAT'(en_ab_q);
        out_cnt_d  = vld_pipe_q[PIPE_LAT-1] ? out_cnt_q + OUT_ADDR_WIDTH'(1) : out_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_RUN;
                    cfg_a_d   = cfg_rows_a;
                    cfg_b_d   = cfg_rows_b;
                    addr_a_d  = '0;
                    addr_b_d  = '0;
                    en_ab_d   = 1'b1;
                    out_cnt_d = '0;
                end
            end
            S_RUN: begin
                // addr_*_q hold the pair being issued this cycle; compute the next one.
                if (addr_b_q == cfg_b_q) begin
                    addr_b_d = '0;
                    if (addr_a_q == cfg_a_q) begin
                        state_d  = S_DRAIN;
                        addr_a_d = '0;
                        en_ab_d  = 1'b0;
                    end else begin
                        addr_a_d = addr_a_q + A_ADDR_WIDTH'(1);
                    end
                end else begin
                    addr_b_d = addr_b_q + B_ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (vld_pipe_q == TAIL_ONLY) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q == S_RUN || state_q == S_DRAIN)) begin
            state_d    = S_IDLE;
            addr_a_d   = '0;
            addr_b_d   = '0;
            en_ab_d    = 1'b0;
            vld_pipe_d = '0;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cfg_a_q    <= '0;
            cfg_b_q    <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            en_ab_q    <= 1'b0;
            vld_pipe_q <= '0;
            out_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_a_q    <= cfg_a_d;
            cfg_b_q    <= cfg_b_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            en_ab_q    <= en_ab_d;
            vld_pipe_q <= vld_pipe_d;
            out_cnt_q  <= out_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign en_A     = en_ab_q;
    assign en_B     = en_ab_q;
    assign we_A     = 1'b0;
    assign we_B     = 1'b0;
    assign addr_A   = addr_a_q;
    assign addr_B   = addr_b_q;
    assign en_out   = vld_pipe_q[PIPE_LAT-1];
    assign we_out   = vld_pipe_q[PIPE_LAT-1];
    assign addr_out = out_cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
